// File: rtl/polyphase_accum_if.sv
// polyphase_accum_if: product-in / commutated-out bus of the polyphase accumulator.
// The master drives the products and rate enables and observes the output; the slave is the accumulator.
interface polyphase_accum_if #(
    parameter int unsigned WIDTH = 18
);
    logic                        sam_clk_en;
    logic                        sys_clk2_en;
    logic signed [2*WIDTH-1:0]   prod_in;
    logic                        prod_valid;
    logic signed [WIDTH-1:0]     e1_in;
    logic signed [WIDTH-1:0]     y_out;
    logic                        y_valid;
    logic                        phase;
    logic                        sat_flag;
    logic                        ovr_flag;

    modport master (
        output sam_clk_en, sys_clk2_en, prod_in, prod_valid, e1_in,
        input  y_out, y_valid, phase, sat_flag, ovr_flag
    );

    modport slave (
        input  sam_clk_en, sys_clk2_en, prod_in, prod_valid, e1_in,
        output y_out, y_valid, phase, sat_flag, ovr_flag
    );
endinterface

// File: rtl/polyphase_accum.sv
// polyphase_accum: accumulates NTAPS products per frame into the E0 branch value.
// It pairs E0 with E1, double-buffers one frame, and commutates E0/E1 onto a 2x-rate stream.
// Optional feature: define POLY_ACCUM_ROUND_EN for round-half-up E0 scaling; the default is truncation.
module polyphase_accum #(
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned NTAPS     = 4,
    parameter int unsigned ACC_GUARD = 2
) (
    input  logic               sys_clk,
    input  logic               reset,
    polyphase_accum_if.slave   bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + ACC_GUARD;
    localparam int unsigned RW = AW + 1;
    localparam int unsigned CW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [CW-1:0]        LAST = CW'(NTAPS - 1);
    localparam logic signed [RW-1:0] MAXV = (RW'(1) << (WIDTH - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;
`ifdef POLY_ACCUM_ROUND_EN
    localparam logic signed [RW-1:0] HALF = RW'(1) << (WIDTH - 2);
`endif

    typedef enum logic {IDLE, SEND_E1} state_t;

    logic signed [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]           pcnt_q, pcnt_d;
    logic signed [WIDTH-1:0] pend_e0_q, pend_e0_d;
    logic signed [WIDTH-1:0] pend_e1_q, pend_e1_d;
    logic                    pend_full_q, pend_full_d;
    logic                    sat_q, sat_d;
    logic                    ovr_q, ovr_d;

    state_t                  state_q;
    logic signed [WIDTH-1:0] out_e1_q;
    logic signed [WIDTH-1:0] y_out_q;
    logic                    y_valid_q;
    logic                    phase_q;

    logic [CW-1:0]           eff_idx_c;
    logic signed [AW-1:0]    prod_ext_c;
    logic signed [AW-1:0]    sum_c;
    logic signed [RW-1:0]    scaled_c;
    logic signed [RW-1:0]    shifted_c;
    logic                    sat_hi_c, sat_lo_c;
    logic signed [WIDTH-1:0] e0_c;
    logic                    complete_c, drop_c, consume_c;

    // Accumulate, scale and saturate E0, and compute the next pending-frame state.
    always_comb begin
        eff_idx_c  = bus.sam_clk_en ? '0 : pcnt_q;
        prod_ext_c = {{ACC_GUARD{bus.prod_in[PW-1]}}, bus.prod_in};
        sum_c      = ((eff_idx_c == '0) ? '0 : acc_q) + prod_ext_c;
`ifdef POLY_ACCUM_ROUND_EN
        scaled_c   = {sum_c[AW-1], sum_c} + HALF;
`else
        scaled_c   = {sum_c[AW-1], sum_c};
`endif
        shifted_c  = scaled_c >>> (WIDTH - 1);
        sat_hi_c   = shifted_c > MAXV;
        sat_lo_c   = shifted_c < MINV;
        e0_c       = sat_hi_c ? MAXV[WIDTH-1:0] :
                     sat_lo_c ? MINV[WIDTH-1:0] : shifted_c[WIDTH-1:0];

        complete_c = bus.prod_valid && (eff_idx_c == LAST);
        drop_c     = bus.sam_clk_en && (pcnt_q != '0);
        consume_c  = bus.sys_clk2_en && (state_q == IDLE) && pend_full_q;

        acc_d       = acc_q;
        pcnt_d      = pcnt_q;
        pend_e0_d   = pend_e0_q;
        pend_e1_d   = pend_e1_q;
        pend_full_d = pend_full_q;
        sat_d       = sat_q;
        ovr_d       = ovr_q | drop_c;

        if (bus.prod_valid) begin
            acc_d  = sum_c;
            pcnt_d = complete_c ? '0 : eff_idx_c + CW'(1);
        end else if (bus.sam_clk_en) begin
            pcnt_d = '0;
        end

        if (complete_c) begin
            pend_e0_d   = e0_c;
            pend_e1_d   = bus.e1_in;
            pend_full_d = 1'b1;
            sat_d       = sat_q | sat_hi_c | sat_lo_c;
            ovr_d       = ovr_d | (pend_full_q && !consume_c);
        end else if (consume_c) begin
            pend_full_d = 1'b0;
        end
    end

    // Accumulator, product counter, pending buffer and sticky flags.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            pcnt_q      <= '0;
            pend_e0_q   <= '0;
            pend_e1_q   <= '0;
            pend_full_q <= 1'b0;
            sat_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            pcnt_q      <= pcnt_d;
            pend_e0_q   <= pend_e0_d;
            pend_e1_q   <= pend_e1_d;
            pend_full_q <= pend_full_d;
            sat_q       <= sat_d;
            ovr_q       <= ovr_d;
        end
    end

    // Commutator: E0 then E1 on successive output-rate enables; y_valid strobes for one cycle.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            out_e1_q  <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (bus.sys_clk2_en) begin
                case (state_q)
                    IDLE: begin
                        if (pend_full_q) begin
                            y_out_q   <= pend_e0_q;
                            out_e1_q  <= pend_e1_q;
                            phase_q   <= 1'b0;
                            y_valid_q <= 1'b1;
                            state_q   <= SEND_E1;
                        end
                    end
                    SEND_E1: begin
                        y_out_q   <= out_e1_q;
                        phase_q   <= 1'b1;
                        y_valid_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.y_out    = y_out_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.phase    = phase_q;
    assign bus.sat_flag = sat_q;
    assign bus.ovr_flag = ovr_q;
endmodule

// File: tb/tb_polyphase_accum.sv
// tb_polyphase_accum: directed self-checking bench for polyphase_accum.
module tb_polyphase_accum;
    localparam int unsigned WIDTH = 18;

    logic sys_clk = 1'b0;
    logic reset   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    polyphase_accum_if #(.WIDTH(WIDTH)) bus ();

    polyphase_accum #(.WIDTH(WIDTH), .NTAPS(4), .ACC_GUARD(2)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int got_n  = 0;

    logic signed [WIDTH-1:0] q_y[$];
    logic                    q_ph[$];
    int                      q_t[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record every output strobe with its cycle stamp.
    always @(negedge sys_clk) begin
        if (bus.y_valid === 1'b1) begin
            q_y.push_back(bus.y_out);
            q_ph.push_back(bus.phase);
            q_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sam_clk_en  = 1'b0;
        bus.prod_valid  = 1'b0;
        bus.prod_in     = '0;
    endtask

    task automatic clear_q();
        q_y.delete();
        q_ph.delete();
        q_t.delete();
    endtask

    task automatic pad_q(input int n);
        got_n = q_y.size();
        while (q_y.size() < n) begin
            q_y.push_back('x);
            q_ph.push_back(1'bx);
            q_t.push_back(-100);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.sys_clk2_en = 1'b0;
        bus.e1_in       = '0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic send(input int n, input logic signed [35:0] a, input logic signed [35:0] b,
                        input logic signed [35:0] c, input logic signed [35:0] d,
                        input logic signed [WIDTH-1:0] e1);
        logic signed [35:0] p[4];
        p[0] = a; p[1] = b; p[2] = c; p[3] = d;
        for (int i = 0; i < n; i++) begin
            bus.sam_clk_en = (i == 0);
            bus.prod_valid = 1'b1;
            bus.prod_in    = p[i];
            bus.e1_in      = e1;
            tick();
        end
        idle_inputs();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            bus.sys_clk2_en = 1'b1;
            tick();
        end
        bus.sys_clk2_en = 1'b0;
        tick();
        pad_q(4);
    endtask

    task automatic test_reset();
        do_reset();
        send(2, 36'sd131072, 36'sd131072, 36'sd0, 36'sd0, 18'sd500);
        @(negedge sys_clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.y_out !== 18'sd0) $display("FAIL reset_y_out got=%0d exp=0", bus.y_out); else passed++;
        checks++; if (bus.y_valid !== 1'b0) $display("FAIL reset_y_valid got=%b exp=0", bus.y_valid); else passed++;
        checks++; if (bus.phase !== 1'b0) $display("FAIL reset_phase got=%b exp=0", bus.phase); else passed++;
        checks++; if ({bus.sat_flag, bus.ovr_flag} !== 2'b00) $display("FAIL reset_flags got=%b%b exp=00", bus.sat_flag, bus.ovr_flag); else passed++;
        tick();
        reset = 1'b1;
        tick();
        clear_q();
        send(4, 36'sd131072, 36'sd131072, 36'sd131072, 36'sd131072, 18'sd500);
        drain(6);
        checks++; if (got_n !== 2) $display("FAIL basic_count got=%0d exp=2", got_n); else passed++;
        checks++; if (q_y[0] !== 18'sd4 || q_ph[0] !== 1'b0) $display("FAIL basic_e0 got=%0d/ph%b exp=4/ph0", q_y[0], q_ph[0]); else passed++;
        checks++; if (q_y[1] !== 18'sd500 || q_ph[1] !== 1'b1) $display("FAIL basic_e1 got=%0d/ph%b exp=500/ph1", q_y[1], q_ph[1]); else passed++;
        checks++; if (q_t[1] - q_t[0] !== 1) $display("FAIL basic_e1_follows got=%0d exp=1", q_t[1] - q_t[0]); else passed++;
        checks++; if ({bus.sat_flag, bus.ovr_flag} !== 2'b00) $display("FAIL basic_flags got=%b%b exp=00", bus.sat_flag, bus.ovr_flag); else passed++;
    endtask

    task automatic test_rounding();
        logic signed [WIDTH-1:0] exp_e0;
`ifdef POLY_ACCUM_ROUND_EN
        exp_e0 = 18'sd1;
`else
        exp_e0 = 18'sd0;
`endif
        clear_q();
        send(4, 36'sd65536, 36'sd0, 36'sd0, 36'sd0, 18'sd7);
        drain(6);
        checks++; if (q_y[0] !== exp_e0) $display("FAIL round_e0 got=%0d exp=%0d", q_y[0], exp_e0); else passed++;
        checks++; if (q_y[1] !== 18'sd7) $display("FAIL round_e1 got=%0d exp=7", q_y[1]); else passed++;
    endtask

    task automatic test_saturation();
        logic signed [35:0] pbig;
        logic signed [35:0] pneg;
        pbig = 36'sd17179738112;
        pneg = -36'sd17179869184;
        clear_q();
        send(4, pbig, pbig, pbig, pbig, -18'sd7);
        drain(6);
        checks++; if (q_y[0] !== 18'sd131071) $display("FAIL sat_pos_e0 got=%0d exp=131071", q_y[0]); else passed++;
        checks++; if (q_y[1] !== -18'sd7) $display("FAIL sat_pos_e1 got=%0d exp=-7", q_y[1]); else passed++;
        checks++; if (bus.sat_flag !== 1'b1) $display("FAIL sat_flag got=%b exp=1", bus.sat_flag); else passed++;
        clear_q();
        send(4, pneg, pneg, pneg, pneg, 18'sd9);
        drain(6);
        checks++; if (q_y[0] !== -18'sd131072) $display("FAIL sat_neg_e0 got=%0d exp=-131072", q_y[0]); else passed++;
        checks++; if (bus.ovr_flag !== 1'b0) $display("FAIL sat_ovr got=%b exp=0", bus.ovr_flag); else passed++;
    endtask

    task automatic test_partial();
        do_reset();
        clear_q();
        send(3, 36'sd131072, 36'sd131072, 36'sd131072, 36'sd0, 18'sd1);
        bus.sam_clk_en = 1'b1;
        tick();
        idle_inputs();
        drain(6);
        checks++; if (got_n !== 0) $display("FAIL partial_no_output got=%0d exp=0", got_n); else passed++;
        checks++; if (bus.ovr_flag !== 1'b1) $display("FAIL partial_ovr got=%b exp=1", bus.ovr_flag); else passed++;
        clear_q();
        send(4, 36'sd131072, 36'sd262144, 36'sd0, -36'sd131072, -18'sd3);
        drain(6);
        checks++; if (got_n !== 2) $display("FAIL partial_next_count got=%0d exp=2", got_n); else passed++;
        checks++; if (q_y[0] !== 18'sd2 || q_y[1] !== -18'sd3) $display("FAIL partial_next got=%0d,%0d exp=2,-3", q_y[0], q_y[1]); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_q();
        send(4, 36'sd131072, 36'sd0, 36'sd0, 36'sd0, 18'sd10);
        send(4, 36'sd262144, 36'sd0, 36'sd0, 36'sd0, 18'sd20);
        send(4, 36'sd393216, 36'sd0, 36'sd0, 36'sd0, 18'sd30);
        tick();
        drain(8);
        checks++; if (got_n !== 2) $display("FAIL b2b_count got=%0d exp=2", got_n); else passed++;
        checks++; if (q_y[0] !== 18'sd3 || q_y[1] !== 18'sd30) $display("FAIL b2b_values got=%0d,%0d exp=3,30", q_y[0], q_y[1]); else passed++;
        checks++; if (bus.ovr_flag !== 1'b1) $display("FAIL b2b_ovr got=%b exp=1", bus.ovr_flag); else passed++;
    endtask

    task automatic test_continuous();
        do_reset();
        clear_q();
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < 4; k++) begin
                bus.sam_clk_en  = (k == 0);
                bus.prod_valid  = 1'b1;
                bus.prod_in     = (k == 0) ? (36'(f) <<< 17) : 36'sd0;
                bus.e1_in       = 18'(100 + f);
                bus.sys_clk2_en = (k % 2 == 0);
                tick();
            end
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            bus.sys_clk2_en = (i % 2 == 0);
            tick();
        end
        bus.sys_clk2_en = 1'b0;
        tick();
        pad_q(34);
        checks++; if (got_n !== 32) $display("FAIL cont_count got=%0d exp=32", got_n); else passed++;
        for (int f = 0; f < 16; f++) begin
            logic ok;
            ok = (q_y[2*f] === 18'(f)) && (q_ph[2*f] === 1'b0) &&
                 (q_y[2*f+1] === 18'(100 + f)) && (q_ph[2*f+1] === 1'b1) &&
                 (q_t[2*f+1] - q_t[2*f] == 2) && (f == 15 || q_t[2*f+2] - q_t[2*f+1] == 2);
            checks++;
            if (!ok) $display("FAIL cont_frame%0d got=%0d/ph%b,%0d/ph%b t=%0d,%0d exp=%0d/ph0,%0d/ph1 spacing 2",
                              f, q_y[2*f], q_ph[2*f], q_y[2*f+1], q_ph[2*f+1], q_t[2*f], q_t[2*f+1], f, 100 + f);
            else passed++;
        end
        checks++; if ({bus.sat_flag, bus.ovr_flag} !== 2'b00) $display("FAIL cont_flags got=%b%b exp=00", bus.sat_flag, bus.ovr_flag); else passed++;
    endtask

    initial begin
        idle_inputs();
        bus.sys_clk2_en = 1'b0;
        bus.e1_in       = '0;
        test_reset();
        test_rounding();
        test_saturation();
        test_partial();
        test_back_to_back();
        test_continuous();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/polyphase_accum.md
# polyphase_accum

Downstream stage of the time-shared polyphase FIR branch. Accumulates the NTAPS full-precision products that the shared multiplier emits per input sample into the E0 branch result. Pairs it with the E1 (centre-tap) value and commutates E0/E1 onto a single 2x-rate output stream with `y_valid` strobes. Double-buffers one frame so the multiplier side and the sys_clk2_en output side decouple.

## Interface
- WIDTH, 18, sample width; products are 2*WIDTH.
- NTAPS, 4, products per sample frame (one per sys_clk while valid).
- ACC_GUARD, 2, accumulator guard bits above 2*WIDTH.

- sys_clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low (0 = reset); one clock, no other reset.
- sam_clk_en  input  1  sample-rate enable; marks start of a new product frame.
- sys_clk2_en  input  1  output-rate (2x sample) enable.
- prod_in  input  2*WIDTH  signed product, 2s16 x 0s18 = full 36-bit format.
- prod_valid  input  1  prod_in valid this cycle.
- e1_in  input  WIDTH  signed E1 branch sample, sampled at frame completion.
- y_out  output  WIDTH  signed commutated output, registered.
- y_valid  output  1  one-cycle strobe per y_out update.
- phase  output  1  0 = y_out is E0, 1 = E1.
- sat_flag  output  1  sticky: E0 result saturated.
- ovr_flag  output  1  sticky: pending frame overwritten or frame truncated.

## Operation
- Accumulator `acc`, signed 2*WIDTH+ACC_GUARD. Product counter `pcnt` 0..NTAPS-1.
- prod_valid with pcnt==0: acc <= sext(prod_in); otherwise acc <= acc + sext(prod_in); pcnt increments, wraps after NTAPS-1.
- Frame complete on the prod_valid cycle with pcnt==NTAPS-1: sum = acc + prod_in; e0 = sat_WIDTH(sum >>> (WIDTH-1)) (bits [2*WIDTH-2:WIDTH-1] of an in-range sum); e1 = e1_in. {e0,e1} written to pending, pend_full <= 1.
- sat_WIDTH clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; any clamp sets sat_flag.
- sam_clk_en with pcnt!=0 and no prod_valid completing the frame: partial frame discarded, pcnt <= 0, ovr_flag set. sam_clk_en and prod_valid in the same cycle: product counts as pcnt==0 of the new frame.
- Frame completes while pend_full=1 and not consumed that cycle: pending overwritten, ovr_flag set.
- Commutator FSM, advances only on sys_clk2_en:
  - IDLE: if pend_full, load out-regs from pending, clear pend_full, emit E0 (y_out=e0, phase=0, y_valid=1) -> SEND_E1. Else stay, y_valid=0.
  - SEND_E1: emit e1 (phase=1, y_valid=1) -> IDLE.
- Consume and complete in the same cycle: the new frame lands in pending (pend_full stays 1), no overrun.
- Reset (async assert): acc=0, pcnt=0, pend_full=0, FSM=IDLE, y_out=0, y_valid=0, phase=0, sat_flag=0, ovr_flag=0. Reset mid-frame or mid-commutation drops all data. Flags clear only by reset.

## Timing
- Frame-complete edge registers pending; earliest E0 emit is the next edge with sys_clk2_en=1 (min latency 2 sys_clk from last product to y_valid).
- E1 follows E0 at the next sys_clk2_en edge; y_out holds between strobes.
- y_valid high exactly one sys_clk per emitted value.
- Throughput: one frame per two sys_clk2_en pulses; nominal 4 sys_clk/sample with sys_clk2_en every 2nd cycle is exactly matched.

## Configuration
- POLY_ACCUM_ROUND_EN defined: E0 = sat_WIDTH((sum + 2^(WIDTH-2)) >>> (WIDTH-1)), round half up.
- Not defined: plain truncation (arithmetic shift, toward -inf).
- E1 path unaffected either way.

## Test plan
- Reset low mid-frame after 2 products, release, 4 products of 131072 each, e1_in=500 -> y_out=4 (phase 0) then 500 (phase 1), no flags.
- 4 products 65536,0,0,0 -> E0=0 truncated; with POLY_ACCUM_ROUND_EN -> E0=1.
- 4 products of 131071*131072 -> E0=131071, sat_flag=1; 4 products of -(2^34) -> E0=-131072, sat_flag=1.
- sam_clk_en after 3 of 4 products -> partial frame dropped, no y_valid, ovr_flag=1; following full frame emits correctly.
- Three back-to-back frames with sys_clk2_en held low, then released -> only third frame emitted, ovr_flag=1.
- Continuous: sys_clk2_en every 2nd cycle, sample every 4 -> y_valid every 2 cycles alternating phase 0/1, no flags for 16 frames.
